// File: rtl/reg_trace_match_bank.sv
// Trace match rule bank: staged pattern/mask/enable registers with an atomic
// commit into the active copies, plus a saturating hit counter per rule.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no commit outstanding
// S_PENDING | commit requested, waiting for matcher idle or for the timeout
// S_APPLY   | staging copied to active at the end of this cycle
module reg_trace_match_bank #(
  parameter int         pBYTECNT_SIZE   = 7,
  parameter int         pBUFFER_SIZE    = 64,
  parameter int         pMATCH_RULES    = 8,
  parameter int         pCOUNT_WIDTH    = 16,
  parameter int         pCOMMIT_TIMEOUT = 255,
  parameter logic [1:0] pSELECT         = 2'b01
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic [7:0]                           reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           read_data,
  input  logic [7:0]                           write_data,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  output logic                                 selected,
  input  logic [pMATCH_RULES-1:0]              I_match_hit,
  input  logic                                 I_matcher_idle,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_pattern,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_mask,
  output logic [pMATCH_RULES-1:0]              O_pattern_enable,
  output logic                                 O_commit_pulse
);

  localparam int BYTES  = pBUFFER_SIZE / 8;
  localparam int CBYTES = pCOUNT_WIDTH / 8;
  localparam int RW     = (pMATCH_RULES > 1) ? $clog2(pMATCH_RULES) : 1;
  localparam int BW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(pCOMMIT_TIMEOUT - 1);

  localparam logic [5:0] A_NAME     = 6'h00;
  localparam logic [5:0] A_REV      = 6'h01;
  localparam logic [5:0] A_NUM      = 6'h02;
  localparam logic [5:0] A_SEL      = 6'h03;
  localparam logic [5:0] A_PATTERN  = 6'h04;
  localparam logic [5:0] A_MASK     = 6'h05;
  localparam logic [5:0] A_ENABLE   = 6'h06;
  localparam logic [5:0] A_COMMIT   = 6'h07;
  localparam logic [5:0] A_STATUS   = 6'h08;
  localparam logic [5:0] A_HITCOUNT = 6'h09;
  localparam logic [5:0] A_HITCLEAR = 6'h0A;

  localparam logic [7:0] NAME_CHARS [8] = '{"M", "t", "c", "h", "B", "a", "n", "k"};

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY} state_t;

  state_t state, state_next;
  logic [15:0] timer, timer_next;
  logic        set_forced, forced, apply;

  logic [7:0]              sel;
  logic [7:0]              stg_pat [pMATCH_RULES][BYTES];
  logic [7:0]              act_pat [pMATCH_RULES][BYTES];
  logic [7:0]              stg_msk [pMATCH_RULES][BYTES];
  logic [7:0]              act_msk [pMATCH_RULES][BYTES];
  logic [pMATCH_RULES-1:0] stg_en, act_en;
  logic [pCOUNT_WIDTH-1:0] hit_cnt [pMATCH_RULES];
  logic [pCOUNT_WIDTH-1:0] snapshot;

  logic [5:0]    addr;
  logic          wr_en, rd_en, rule_ok, byte_ok;
  logic [RW-1:0] rule_idx;
  logic [BW-1:0] byte_idx;
  logic [31:0]   en32, snap32;
  logic [7:0]    rd_mux;

  assign selected = reg_addrvalid & (reg_address[7:6] == pSELECT);
  assign addr     = reg_address[5:0];
  assign wr_en    = selected & reg_write;
  assign rd_en    = selected & reg_read;
  assign rule_idx = sel[RW-1:0];
  assign byte_idx = reg_bytecnt[BW-1:0];
  assign rule_ok  = (32'(sel[6:0]) < pMATCH_RULES);
  assign byte_ok  = (32'(reg_bytecnt) < BYTES);
  assign apply    = (state == S_APPLY);

  // Commit FSM state, timeout timer, sticky forced flag and the commit pulse
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      timer          <= '0;
      forced         <= 1'b0;
      O_commit_pulse <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      O_commit_pulse <= apply;
      if (set_forced)
        forced <= 1'b1;
      else if (wr_en && addr == A_STATUS)
        forced <= 1'b0;
    end
  end

  // Commit FSM next state; a COMMIT outside IDLE is dropped
  always_comb begin
    state_next = state;
    timer_next = timer;
    set_forced = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_en && addr == A_COMMIT) begin
          state_next = S_PENDING;
          timer_next = '0;
        end
      end
      S_PENDING: begin
        if (I_matcher_idle) begin
          state_next = S_APPLY;
        end else if (timer == TIMEOUT_LAST) begin
          state_next = S_APPLY;
          set_forced = 1'b1;
        end else begin
          timer_next = timer + 16'd1;
        end
      end
      S_APPLY: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Staging writes and the atomic copy; APPLY takes the pre-write staging value
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= '0;
      stg_en <= '0;
      act_en <= '0;
      for (int r = 0; r < pMATCH_RULES; r++) begin
        for (int b = 0; b < BYTES; b++) begin
          stg_pat[r][b] <= 8'h00;
          act_pat[r][b] <= 8'h00;
          stg_msk[r][b] <= 8'hFF;
          act_msk[r][b] <= 8'hFF;
        end
      end
    end else begin
      if (apply) begin
        act_pat <= stg_pat;
        act_msk <= stg_msk;
        act_en  <= stg_en;
      end
      if (wr_en) begin
        case (addr)
          A_SEL:     sel <= write_data;
          A_PATTERN: if (rule_ok && byte_ok) stg_pat[rule_idx][byte_idx] <= write_data;
          A_MASK:    if (rule_ok && byte_ok) stg_msk[rule_idx][byte_idx] <= write_data;
          A_ENABLE: begin
            for (int r = 0; r < pMATCH_RULES; r++)
              if (32'(reg_bytecnt) == (r >> 3)) stg_en[r] <= write_data[r[2:0]];
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating hit counters; a clear beats a coincident hit
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot <= '0;
      for (int r = 0; r < pMATCH_RULES; r++) hit_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < pMATCH_RULES; r++) begin
        if (wr_en && addr == A_HITCLEAR && rule_ok && rule_idx == RW'(r))
          hit_cnt[r] <= '0;
        else if (I_match_hit[r] && hit_cnt[r] != '1)
          hit_cnt[r] <= hit_cnt[r] + pCOUNT_WIDTH'(1);
      end
      if (rd_en && addr == A_HITCOUNT && rule_ok && reg_bytecnt == '0)
        snapshot <= hit_cnt[rule_idx];
    end
  end

  // Combinational read mux; SEL[7] picks the active view of rule registers
  always_comb begin
    rd_mux = 8'h00;
    en32   = 32'(sel[7] ? act_en : stg_en);
    snap32 = 32'(snapshot);
    case (addr)
      A_NAME:    if (32'(reg_bytecnt) < 8) rd_mux = NAME_CHARS[reg_bytecnt[2:0]];
      A_REV:     rd_mux = 8'h02;
      A_NUM:     rd_mux = 8'(pMATCH_RULES);
      A_SEL:     rd_mux = sel;
      A_PATTERN: if (rule_ok && byte_ok)
                   rd_mux = sel[7] ? act_pat[rule_idx][byte_idx] : stg_pat[rule_idx][byte_idx];
      A_MASK:    if (rule_ok && byte_ok)
                   rd_mux = sel[7] ? act_msk[rule_idx][byte_idx] : stg_msk[rule_idx][byte_idx];
      A_ENABLE:  if (32'(reg_bytecnt) < 4) rd_mux = en32[{reg_bytecnt[1:0], 3'b000} +: 8];
      A_STATUS:  rd_mux = {6'b0, forced, state == S_PENDING};
      A_HITCOUNT: begin
        if (rule_ok) begin
          if (reg_bytecnt == '0)
            rd_mux = hit_cnt[rule_idx][7:0];
          else if (32'(reg_bytecnt) < CBYTES)
            rd_mux = snap32[{reg_bytecnt[1:0], 3'b000} +: 8];
        end
      end
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data, zero when no read is in progress
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) read_data <= 8'h00;
    else          read_data <= rd_en ? rd_mux : 8'h00;
  end

  for (genvar r = 0; r < pMATCH_RULES; r++) begin : g_rule
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign O_pattern[r*pBUFFER_SIZE + b*8 +: 8] = act_pat[r][b];
      assign O_mask[r*pBUFFER_SIZE + b*8 +: 8]    = act_msk[r][b];
    end
  end
  assign O_pattern_enable = act_en;

endmodule

// File: tb/tb_reg_trace_match_bank.sv
// Directed bench for reg_trace_match_bank with default parameters.
module tb_reg_trace_match_bank;

  localparam logic [1:0] BANK = 2'b01;

  logic         usb_clk = 1'b0;
  logic         reset_n;
  logic [7:0]   reg_address;
  logic [6:0]   reg_bytecnt;
  logic [7:0]   read_data;
  logic [7:0]   write_data;
  logic         reg_read, reg_write, reg_addrvalid;
  logic         selected;
  logic [7:0]   I_match_hit;
  logic         I_matcher_idle;
  logic [511:0] O_pattern, O_mask;
  logic [7:0]   O_pattern_enable;
  logic         O_commit_pulse;

  int tests = 0;
  int fails = 0;

  reg_trace_match_bank dut (
    .usb_clk(usb_clk), .reset_n(reset_n), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .read_data(read_data), .write_data(write_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .selected(selected), .I_match_hit(I_match_hit), .I_matcher_idle(I_matcher_idle),
    .O_pattern(O_pattern), .O_mask(O_mask), .O_pattern_enable(O_pattern_enable),
    .O_commit_pulse(O_commit_pulse)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [6:0] bc, input logic [7:0] d);
    reg_address = {BANK, a}; reg_bytecnt = bc; write_data = d;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    @(posedge usb_clk); #1;
    reg_addrvalid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [6:0] bc, output logic [7:0] d);
    reg_address = {BANK, a}; reg_bytecnt = bc;
    reg_addrvalid = 1'b1; reg_read = 1'b1;
    @(posedge usb_clk); #1;
    reg_addrvalid = 1'b0; reg_read = 1'b0;
    d = read_data;
  endtask

  initial begin
    logic [7:0]  d;
    logic [63:0] name_exp;
    logic        ok;
    name_exp = "MtchBank";

    reset_n = 1'b0; reg_address = '0; reg_bytecnt = '0; write_data = '0;
    reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
    I_match_hit = '0; I_matcher_idle = 1'b1;
    #22;
    check("rst_pattern", 64'(O_pattern === '0), 64'd1);
    check("rst_mask", 64'(O_mask === {512{1'b1}}), 64'd1);
    check("rst_enable", 64'(O_pattern_enable), 64'h00);
    check("rst_pulse", 64'(O_commit_pulse), 64'h0);
    check("rst_rdata", 64'(read_data), 64'h00);
    @(posedge usb_clk); #1 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd(6'h00, 7'(i), d);
      check("name", 64'(d), 64'(name_exp[63-8*i -: 8]));
    end
    rd(6'h01, 0, d); check("rev", 64'(d), 64'h02);
    rd(6'h02, 0, d); check("num_rules", 64'(d), 64'h08);
    rd(6'h0B, 0, d); check("unmapped", 64'(d), 64'h00);

    reg_address = 8'h82; reg_addrvalid = 1'b1; reg_read = 1'b1; #1;
    check("other_bank_sel", 64'(selected), 64'h0);
    @(posedge usb_clk); #1;
    reg_addrvalid = 1'b0; reg_read = 1'b0;
    check("other_bank_rd", 64'(read_data), 64'h00);

    // stage rule 3 and commit with the matcher idle
    wr(6'h03, 0, 8'h03);
    for (int i = 0; i < 8; i++) wr(6'h04, 7'(i), 8'(8'h11 * (i + 1)));
    wr(6'h05, 0, 8'h00);
    wr(6'h06, 0, 8'h08);
    rd(6'h04, 7, d); check("stg_pat_b7", 64'(d), 64'h88);
    check("pre_commit_pat", O_pattern[3*64 +: 64], 64'h0);
    wr(6'h07, 0, 8'h00);
    check("k0_pulse", 64'(O_commit_pulse), 64'h0);
    check("k0_enable", 64'(O_pattern_enable), 64'h00);
    @(posedge usb_clk); #1;
    check("k1_pulse", 64'(O_commit_pulse), 64'h0);
    check("k1_pattern", O_pattern[3*64 +: 64], 64'h0);
    @(posedge usb_clk); #1;
    check("k2_pulse", 64'(O_commit_pulse), 64'h1);
    check("k2_pattern", O_pattern[3*64 +: 64], 64'h8877665544332211);
    check("k2_mask", O_mask[3*64 +: 64], 64'hFFFFFFFFFFFFFF00);
    check("k2_enable", 64'(O_pattern_enable), 64'h08);
    check("k2_rule2", O_pattern[2*64 +: 64], 64'h0);
    @(posedge usb_clk); #1;
    check("k3_pulse", 64'(O_commit_pulse), 64'h0);
    wr(6'h03, 0, 8'h83);
    rd(6'h04, 2, d); check("act_pat_b2", 64'(d), 64'h33);
    rd(6'h06, 0, d); check("act_enable", 64'(d), 64'h08);
    rd(6'h06, 1, d); check("enable_b1", 64'(d), 64'h00);

    // out-of-range rule and byte
    wr(6'h03, 0, 8'h09);
    wr(6'h04, 0, 8'hEE);
    rd(6'h04, 0, d); check("oor_rule_rd", 64'(d), 64'h00);
    wr(6'h03, 0, 8'h03);
    rd(6'h04, 8, d); check("oor_byte_rd", 64'(d), 64'h00);

    // forced commit after the timeout
    I_matcher_idle = 1'b0;
    wr(6'h04, 0, 8'h5A);
    wr(6'h07, 0, 8'h00);
    rd(6'h08, 0, d); check("status_pending", 64'(d), 64'h01);
    ok = 1'b1;
    repeat (254) begin
      @(posedge usb_clk); #1;
      if (O_commit_pulse !== 1'b0 || O_pattern[3*64 +: 8] !== 8'h11) ok = 1'b0;
    end
    check("no_early_apply", 64'(ok), 64'h1);
    @(posedge usb_clk); #1;
    check("timeout_pulse", 64'(O_commit_pulse), 64'h1);
    check("timeout_pat", 64'(O_pattern[3*64 +: 8]), 64'h5A);
    rd(6'h08, 0, d); check("status_forced", 64'(d), 64'h02);
    wr(6'h08, 0, 8'h00);
    rd(6'h08, 0, d); check("status_cleared", 64'(d), 64'h00);
    I_matcher_idle = 1'b1;

    // hit counter, snapshot and saturation on rule 5
    wr(6'h03, 0, 8'h05);
    I_match_hit = 8'h20;
    repeat (291) @(posedge usb_clk);
    #1 I_match_hit = 8'h00;
    rd(6'h09, 0, d); check("hit_b0", 64'(d), 64'h23);
    I_match_hit = 8'h20;
    repeat (256) @(posedge usb_clk);
    #1 I_match_hit = 8'h00;
    rd(6'h09, 1, d); check("hit_snap_b1", 64'(d), 64'h01);
    rd(6'h09, 0, d); check("hit_live_b0", 64'(d), 64'h23);
    rd(6'h09, 1, d); check("hit_new_snap_b1", 64'(d), 64'h02);
    rd(6'h09, 2, d); check("hit_b2_oor", 64'(d), 64'h00);
    I_match_hit = 8'h20;
    repeat (66000) @(posedge usb_clk);
    #1 I_match_hit = 8'h00;
    rd(6'h09, 0, d); check("sat_b0", 64'(d), 64'hFF);
    rd(6'h09, 1, d); check("sat_b1", 64'(d), 64'hFF);
    wr(6'h03, 0, 8'h04);
    rd(6'h09, 0, d); check("rule4_hits", 64'(d), 64'h00);
    wr(6'h03, 0, 8'h05);
    I_match_hit = 8'h20;
    wr(6'h0A, 0, 8'h00);
    I_match_hit = 8'h00;
    rd(6'h09, 0, d); check("clr_b0", 64'(d), 64'h00);
    rd(6'h09, 1, d); check("clr_b1", 64'(d), 64'h00);

    // staging write in the APPLY cycle
    wr(6'h03, 0, 8'h03);
    wr(6'h04, 0, 8'h77);
    wr(6'h07, 0, 8'h00);
    @(posedge usb_clk); #1;
    wr(6'h04, 0, 8'hAA);
    check("apply_wr_pulse", 64'(O_commit_pulse), 64'h1);
    check("apply_wr_act", 64'(O_pattern[3*64 +: 8]), 64'h77);
    rd(6'h04, 0, d); check("apply_wr_stg", 64'(d), 64'hAA);
    wr(6'h03, 0, 8'h83);
    rd(6'h04, 0, d); check("apply_wr_actview", 64'(d), 64'h77);

    // reset while a commit is pending
    I_matcher_idle = 1'b0;
    wr(6'h07, 0, 8'h00);
    repeat (5) @(posedge usb_clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_pattern", O_pattern[3*64 +: 64], 64'h0);
    check("midrst_enable", 64'(O_pattern_enable), 64'h00);
    check("midrst_mask", 64'(O_mask === {512{1'b1}}), 64'd1);
    @(posedge usb_clk); #1 reset_n = 1'b1;
    I_matcher_idle = 1'b1;
    ok = 1'b1;
    repeat (300) begin
      @(posedge usb_clk); #1;
      if (O_commit_pulse !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_pulse", 64'(ok), 64'h1);
    rd(6'h08, 0, d); check("midrst_status", 64'(d), 64'h00);
    rd(6'h03, 0, d); check("midrst_sel", 64'(d), 64'h00);
    wr(6'h03, 0, 8'h03);
    rd(6'h04, 0, d); check("midrst_stg", 64'(d), 64'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
